// File: rtl/dm_sync_bytewe.sv
// rtl/dm_sync_bytewe.sv - byte-strobed data memory with registered read and post-reset clear sequencer
// Optional macro DM_BOUNDS_CHECK_EN adds the DM_err output.
module dm_sync_bytewe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                DM_read,
    input  logic                DM_write,
    input  logic [DATA_W/8-1:0] DM_wstrb,
    input  logic [ADDR_W-1:0]   DM_address,
    input  logic [DATA_W-1:0]   DM_in,
    output logic [DATA_W-1:0]   DM_out,
    output logic                DM_valid,
    output logic                DM_ready
`ifdef DM_BOUNDS_CHECK_EN
   ,output logic                DM_err
`endif
);

    localparam int              LANES    = DATA_W / 8;
    localparam logic [0:0]      ST_CLEAR = 1'b0;
    localparam logic [0:0]      ST_RUN   = 1'b1;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_out;
    logic              r_valid;

    logic              w_run;
    logic              w_in_range;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [LANES-1:0]  w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_fwd_word;

    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_in_range = ({1'b0, DM_address} < LP_DEPTH);
        w_wr_en    = w_run && DM_write && w_in_range;
        w_rd_en    = w_run && DM_read;
        // The single write port is shared between the clear sequencer and normal stores.
        if (w_run) begin
            w_mem_waddr = DM_address;
            w_mem_wdata = DM_in;
            w_mem_we    = w_wr_en ? DM_wstrb : '0;
        end else begin
            w_mem_waddr = r_clr_cnt;
            w_mem_wdata = '0;
            w_mem_we    = '1;
        end
        w_rd_word = w_in_range ? r_mem[DM_address] : '0;
    end

    // Write-first: strobed lanes of a same-cycle store override the stored word.
    always_comb begin
        w_fwd_word = w_rd_word;
        for (int k = 0; k < LANES; k++) begin
            if (w_wr_en && DM_wstrb[k]) begin
                w_fwd_word[8*k +: 8] = DM_in[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (w_mem_we[k]) begin
                r_mem[w_mem_waddr][8*k +: 8] <= w_mem_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            if (r_clr_cnt == LP_LAST) begin
                r_state <= ST_RUN;
            end else begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_en;
            r_out   <= w_rd_en ? w_fwd_word : '0;
        end
    end

`ifdef DM_BOUNDS_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (DM_read || DM_write) && (!w_run || !w_in_range);
        end
    end

    assign DM_err = r_err;
`endif

    assign DM_out   = r_out;
    assign DM_valid = r_valid;
    assign DM_ready = w_run;

endmodule

// File: tb/tb_dm_sync_bytewe.sv
// tb/tb_dm_sync_bytewe.sv - randomized self-checking bench for dm_sync_bytewe against an array model
module tb_dm_sync_bytewe;

    localparam int DEPTH  = 12;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              DM_read = 1'b0;
    logic              DM_write = 1'b0;
    logic [3:0]        DM_wstrb = '0;
    logic [ADDR_W-1:0] DM_address = '0;
    logic [31:0]       DM_in = '0;
    logic [31:0]       DM_out;
    logic              DM_valid;
    logic              DM_ready;
`ifdef DM_BOUNDS_CHECK_EN
    logic              DM_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [DEPTH];
    int          m_since_rel;
    bit          m_ready;

    dm_sync_bytewe #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .DM_read(DM_read), .DM_write(DM_write), .DM_wstrb(DM_wstrb),
        .DM_address(DM_address), .DM_in(DM_in),
        .DM_out(DM_out), .DM_valid(DM_valid), .DM_ready(DM_ready)
`ifdef DM_BOUNDS_CHECK_EN
       ,.DM_err(DM_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic release_reset();
        DM_read = 0; DM_write = 0; DM_wstrb = '0; DM_address = '0; DM_in = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_out", DM_out, 32'h0);
        check_eq("rst_valid", {31'b0, DM_valid}, 32'h0);
        check_eq("rst_ready", {31'b0, DM_ready}, 32'h0);
        rst = 1'b0;
        m_since_rel = 0;
        m_ready = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    endtask

    task automatic step(input bit rd, input bit wr, input logic [3:0] st,
                        input logic [ADDR_W-1:0] a, input logic [31:0] d);
        logic [31:0] e_out;
        bit          e_valid, e_err, in_rng;
        DM_read = rd; DM_write = wr; DM_wstrb = st; DM_address = a; DM_in = d;
        in_rng  = (int'(a) < DEPTH);
        if (m_ready && wr && in_rng)
            for (int k = 0; k < 4; k++)
                if (st[k]) m_mem[a][8*k +: 8] = d[8*k +: 8];
        e_valid = m_ready && rd;
        e_out   = (e_valid && in_rng) ? m_mem[a] : 32'h0;
        e_err   = (rd || wr) && (!m_ready || !in_rng);
        @(posedge clk); #1;
        m_since_rel++;
        m_ready = (m_since_rel >= DEPTH);
        check_eq("valid", {31'b0, DM_valid}, {31'b0, e_valid});
        check_eq("out", DM_out, e_out);
        check_eq("ready", {31'b0, DM_ready}, {31'b0, m_ready});
`ifdef DM_BOUNDS_CHECK_EN
        check_eq("err", {31'b0, DM_err}, {31'b0, e_err});
`else
        if (e_err) e_err = 0;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'h0, '0, 32'h0);
    endtask

    initial begin
        release_reset();
        // Requests during clear are ignored; a write to addr 4 must not land.
        step(1, 1, 4'hF, 4'd4, 32'h12345678);
        idle(DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 4'h0, ADDR_W'(i), 32'h0);

        step(0, 1, 4'b1111, 4'd5, 32'hAABBCCDD);
        step(0, 1, 4'b0101, 4'd5, 32'h11223344);
        step(1, 0, 4'b0000, 4'd5, 32'h0);
        check_eq("strobe_word", DM_out, 32'hAA22CC44);

        step(1, 1, 4'b1100, 4'd7, 32'hDEADBEEF);
        check_eq("collision", DM_out, 32'hDEAD0000);

        step(0, 1, 4'hF, 4'd1, 32'h1);
        step(0, 1, 4'hF, 4'd2, 32'h2);
        step(0, 1, 4'hF, 4'd3, 32'h3);
        step(1, 0, 4'h0, 4'd1, 32'h0);
        check_eq("b2b_1", DM_out, 32'h1);
        step(1, 0, 4'h0, 4'd2, 32'h0);
        check_eq("b2b_2", DM_out, 32'h2);
        step(1, 0, 4'h0, 4'd3, 32'h0);
        check_eq("b2b_3", DM_out, 32'h3);
        idle(1);

        step(1, 0, 4'h0, 4'd13, 32'h0);
        check_eq("oor_read", DM_out, 32'h0);
        step(0, 1, 4'hF, 4'd13, 32'hFFFFFFFF);
        step(1, 0, 4'h0, 4'd1, 32'h0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom), 1'($urandom), 4'($urandom), ADDR_W'($urandom_range(0, 15)), $urandom);

        // Asynchronous reset while a read result is on the output.
        step(0, 1, 4'hF, 4'd10, 32'hCAFEF00D);
        step(1, 0, 4'h0, 4'd10, 32'h0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", {31'b0, DM_valid}, 32'h0);
        check_eq("arst_out", DM_out, 32'h0);
        check_eq("arst_ready", {31'b0, DM_ready}, 32'h0);
        release_reset();
        idle(8);
        #2 rst = 1'b1;
        #1;
        check_eq("midclr_ready", {31'b0, DM_ready}, 32'h0);
        release_reset();
        idle(DEPTH);
        step(1, 0, 4'h0, 4'd10, 32'h0);
        check_eq("cleared_10", DM_out, 32'h0);

        for (int i = 0; i < 200; i++)
            step(1'($urandom), 1'($urandom), 4'($urandom), ADDR_W'($urandom_range(0, 15)), $urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
